// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle MIPS-subset control FSM with memory-ready stalls and
//             a retired-instruction counter. Optional illegal-opcode trap
//             enabled by defining MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int              OP_W     = 6,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0] OP_J     = 6'b000010,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_opcode;
    logic [CNT_W-1:0]  r_retired;
    logic              w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_opcode <= opcode;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_retire      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                alu_src_b = 2'b11;
                alu_op    = 2'b00;
                if (opcode == OP_LW || opcode == OP_SW)
                    w_next = S_MEMADR;
                else if (opcode == OP_RTYPE)
                    w_next = S_EXEC;
                else if (opcode == OP_BEQ)
                    w_next = S_BRANCH;
                else if (opcode == OP_J)
                    w_next = S_JUMP;
                else if (opcode == OP_ADDI)
                    w_next = S_ADDIEX;
                else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                w_retire  = mem_ready;
                w_next    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_retire  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                w_retire = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_next = S_TRAP;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
        // Strobes must be quiet while reset is held, independent of mem_ready.
        if (!rst_n) begin
            {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, w_retire} = '0;
        end
    end

    assign instr_done = w_retire;
    assign retired    = r_retired;
    assign state      = r_state;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign illegal = rst_n && (r_state == S_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl: latency table, reset
//             and wrap sequences, randomized instruction stream vs. model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif
    logic [15:0]      act_ctrl;

    int tests  = 0;
    int failed = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_done(instr_done), .retired(retired),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state(state)
    );

    assign act_ctrl = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                       alu_src_b, alu_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control strobes each state must show, straight from the state table.
    function automatic logic [15:0] exp_ctrl(input int s, input bit mr);
        logic pw, pwc, iord, mrd, mw, irw, rd, m2r, rw, asa;
        logic [1:0] psrc, asb, aop;
        {pw, pwc, iord, mrd, mw, irw, rd, m2r, rw, asa} = '0;
        psrc = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            1:  begin asb = 2'b11; aop = 2'b00; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, psrc, iord, mrd, mw, irw, rd, m2r, rw, asa, asb, aop};
    endfunction

    // Reference model: an instruction is a list of visited states; FETCH,
    // MEMRD and MEMWR wait for mem_ready; the last state retires.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input bit rnd, output int cycles);
        int st[$];
        int idx;
        int stalls;
        st.push_back(0);
        st.push_back(1);
        case (op)
            OP_LW:    begin st.push_back(2); st.push_back(3); st.push_back(4); end
            OP_SW:    begin st.push_back(2); st.push_back(5); end
            OP_RTYPE: begin st.push_back(6); st.push_back(7); end
            OP_ADDI:  begin st.push_back(10); st.push_back(11); end
            OP_BEQ:   st.push_back(8);
            OP_J:     st.push_back(9);
            default:  ;
        endcase
        idx = 0; cycles = 0; stalls = 0;
        while (idx < st.size() && cycles < 64) begin
            bit is_mem, mr, adv, last;
            is_mem = (st[idx] == 0) || (st[idx] == 3) || (st[idx] == 5);
            if (is_mem) begin
                if (rnd) mr = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                else     mr = (stalls < ((st[idx] == 0) ? fstall : mstall)) ? 1'b0 : 1'b1;
            end else begin
                mr = 1'($urandom);
            end
            if (is_mem && !mr) stalls++;
            mem_ready = mr;
            opcode    = (st[idx] == 1) ? op : 6'($urandom);
            adv  = !is_mem || mr;
            last = (idx == st.size() - 1);
            @(negedge clk);
            check("state", {28'd0, state}, st[idx]);
            check("ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl(st[idx], mr)});
            check("instr_done", {31'd0, instr_done}, {31'd0, last && adv});
            check("retired", {24'd0, retired}, exp_retired);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            check("illegal", {31'd0, illegal}, 0);
`endif
            @(posedge clk); #1;
            cycles++;
            if (adv) begin idx++; stalls = 0; end
            if (last && adv) exp_retired = (exp_retired + 1) & CNT_MAX;
        end
        if (idx < st.size()) begin
            tests++; failed++;
            $display("FAIL timeout: instruction %0h did not complete, got %0d cycles, expected fewer than 64", op, cycles);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         fstall;
        int         mstall;
        int         exp_cycles;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [5:0] ops[8];
        int cyc, c1, c2, nops, guard;

        tbl.push_back('{OP_RTYPE, 0, 0, 4});
        tbl.push_back('{OP_ADDI,  0, 0, 4});
        tbl.push_back('{OP_SW,    0, 0, 4});
        tbl.push_back('{OP_LW,    0, 0, 5});
        tbl.push_back('{OP_BEQ,   0, 0, 3});
        tbl.push_back('{OP_J,     0, 0, 3});
        tbl.push_back('{OP_LW,    0, 2, 7});
        tbl.push_back('{OP_SW,    1, 1, 6});
        tbl.push_back('{OP_RTYPE, 2, 0, 6});
        tbl.push_back('{OP_J,     3, 0, 6});
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{6'b111111, 0, 0, 2});
        tbl.push_back('{6'b000001, 1, 0, 3});
`endif

        // Reset state.
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {28'd0, state}, 0);
        check("rst_ctrl", {16'd0, act_ctrl}, 0);
        check("rst_done", {31'd0, instr_done}, 0);
        check("rst_retired", {24'd0, retired}, 0);
        rst_n = 1'b1;
        exp_retired = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_instr(tbl[i].op, tbl[i].fstall, tbl[i].mstall, 1'b0, cyc);
            check($sformatf("latency[%0d]", i), cyc, tbl[i].exp_cycles);
        end

        // Asynchronous reset while a load waits in MEMRD.
        mem_ready = 1'b1; opcode = '0;
        @(posedge clk); #1;
        opcode = OP_LW; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("memrd_state", {28'd0, state}, 3);
        #2 rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check("midrst_state", {28'd0, state}, 0);
        check("midrst_ctrl", {16'd0, act_ctrl}, 0);
        check("midrst_done", {31'd0, instr_done}, 0);
        check("midrst_retired", {24'd0, retired}, 0);
        @(posedge clk); #1;
        check("inrst_ctrl", {16'd0, act_ctrl}, 0);
        mem_ready = 1'b0; rst_n = 1'b1;
        exp_retired = 0;
        @(negedge clk);
        check("resume_state", {28'd0, state}, 0);
        check("resume_mem_read", {31'd0, mem_read}, 1);
        check("resume_ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl(0, 1'b0)});
        @(posedge clk); #1;

        // SW then BEQ back to back.
        run_instr(OP_SW, 0, 0, 1'b0, c1);
        run_instr(OP_BEQ, 0, 0, 1'b0, c2);
        check("sw_beq_cycles", c1 + c2, 7);
        check("sw_beq_retired", {24'd0, retired}, 2);

        // Randomized instruction stream.
        ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'b111111, 6'b010001};
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        nops = 6;
`else
        nops = 8;
`endif
        for (int n = 0; n < 300; n++)
            run_instr(ops[$urandom_range(0, nops - 1)], 0, 0, 1'b1, cyc);

        // Counter wraparound.
        guard = 0;
        while (exp_retired != CNT_MAX && guard < 400) begin
            run_instr(OP_J, 0, 0, 1'b0, cyc);
            guard++;
        end
        check("pre_wrap", {24'd0, retired}, CNT_MAX);
        run_instr(OP_J, 0, 0, 1'b0, cyc);
        check("wrap", {24'd0, retired}, 0);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        begin
            int r0;
            r0 = exp_retired;
            mem_ready = 1'b1; opcode = '0;
            @(negedge clk);
            check("trap_fetch", {28'd0, state}, 0);
            @(posedge clk); #1;
            opcode = 6'b111111;
            @(negedge clk);
            check("trap_decode", {28'd0, state}, 1);
            check("trap_decode_done", {31'd0, instr_done}, 0);
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) begin
                mem_ready = 1'($urandom); opcode = 6'($urandom);
                @(negedge clk);
                check("trap_state", {28'd0, state}, 12);
                check("trap_illegal", {31'd0, illegal}, 1);
                check("trap_ctrl", {16'd0, act_ctrl}, 0);
                check("trap_done", {31'd0, instr_done}, 0);
                check("trap_retired", {24'd0, retired}, r0);
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            #1;
            check("trap_rst_state", {28'd0, state}, 0);
            check("trap_rst_illegal", {31'd0, illegal}, 0);
            rst_n = 1'b1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
